des_key_sched_seq: RTL and testbench

DES_KEY_SCHED_SEQ -- requirements
Module: des_key_sched_seq

---
 rtl/des_key_sched_seq.sv | 208 ++++++++++++++++++++
 tb/tb_des_key_sched_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched_seq.sv
// DES key schedule generator: streams the sixteen PC-2 round keys of each stage over a
// valid/ready handshake, for single DES or three-key TDEA (EDE) schedules.
module des_key_sched_seq #(
    parameter int unsigned KEY_STAGES   = 1,
    parameter int unsigned PARITY_CHECK = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      des_mode,
    input  logic [64*KEY_STAGES-1:0]  key_in,
    input  logic                      out_ready,
    output logic                      rk_valid,
    output logic [47:0]               rk,
    output logic [3:0]                rk_round,
    output logic [1:0]                rk_stage,
    output logic                      rk_last,
    output logic                      busy,
    output logic                      done,
    output logic                      parity_err
);

    localparam int unsigned PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int unsigned PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Table entries use DES numbering: bit 1 is the MSB of the vector.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        for (int i = 0; i < 56; i++) o[55-i] = k[64-PC1[i]];
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2[i]];
        return o;
    endfunction

    typedef enum logic [1:0] {StIdle, StLoad, StGen} state_e;

    state_e                    state_q, state_d;
    logic [64*KEY_STAGES-1:0]  key_q, key_d;
    logic                      mode_q, mode_d;
    logic [1:0]                stage_q, stage_d;
    logic [3:0]                round_q, round_d;
    logic [27:0]               c_q, c_d, d_q, d_d;
    logic [47:0]               rk_q, rk_d;
    logic                      valid_q, valid_d;
    logic                      done_q, done_d;
    logic                      perr_q, perr_d;

    logic [63:0] stage_key;
    logic        dec_dir;
    logic        key_bad;
    logic [55:0] cd_pc1;
    logic [27:0] c_load, d_load, c_rot, d_rot;
    logic [3:0]  round_nxt;
    logic        shift_one;
    logic        last_stage;

    assign dec_dir    = (KEY_STAGES == 3) ? (mode_q ^ (stage_q == 2'd1)) : mode_q;
    assign last_stage = (stage_q == 2'(KEY_STAGES - 1));
    assign round_nxt  = round_q + 4'd1;
    assign shift_one  = (round_nxt == 4'd1) || (round_nxt == 4'd8) || (round_nxt == 4'd15);

    // TDEA decrypt walks the key bundle backwards: K3, K2, K1.
    always_comb begin
        int key_idx;
        stage_key = '0;
        key_idx   = (KEY_STAGES == 3 && mode_q) ? 2 - int'(stage_q) : int'(stage_q);
        for (int s = 0; s < int'(KEY_STAGES); s++) begin
            if (s == key_idx) stage_key = key_q[64*s +: 64];
        end
    end

    always_comb begin
        key_bad = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if ((^stage_key[8*b +: 8]) == 1'b0) key_bad = 1'b1;
        end
    end

    // Decrypt starts from the unrotated PC-1 halves, i.e. the round-16 key.
    always_comb begin
        cd_pc1 = pc1(stage_key);
        if (dec_dir) begin
            c_load = cd_pc1[55:28];
            d_load = cd_pc1[27:0];
            c_rot  = shift_one ? {c_q[0], c_q[27:1]} : {c_q[1:0], c_q[27:2]};
            d_rot  = shift_one ? {d_q[0], d_q[27:1]} : {d_q[1:0], d_q[27:2]};
        end else begin
            c_load = {cd_pc1[54:28], cd_pc1[55]};
            d_load = {cd_pc1[26:0], cd_pc1[27]};
            c_rot  = shift_one ? {c_q[26:0], c_q[27]} : {c_q[25:0], c_q[27:26]};
            d_rot  = shift_one ? {d_q[26:0], d_q[27]} : {d_q[25:0], d_q[27:26]};
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        mode_d  = mode_q;
        stage_d = stage_q;
        round_d = round_q;
        c_d     = c_q;
        d_d     = d_q;
        rk_d    = rk_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        perr_d  = perr_q;
        if (abort) begin
            state_d = StIdle;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StLoad;
                        key_d   = key_in;
                        mode_d  = des_mode;
                        stage_d = 2'd0;
                        round_d = 4'd0;
                        perr_d  = 1'b0;
                    end
                end
                StLoad: begin
                    c_d     = c_load;
                    d_d     = d_load;
                    rk_d    = pc2({c_load, d_load});
                    round_d = 4'd0;
                    valid_d = 1'b1;
                    state_d = StGen;
                    if (PARITY_CHECK != 0 && key_bad) perr_d = 1'b1;
                end
                StGen: begin
                    if (valid_q && out_ready) begin
                        if (round_q != 4'd15) begin
                            c_d     = c_rot;
                            d_d     = d_rot;
                            rk_d    = pc2({c_rot, d_rot});
                            round_d = round_nxt;
                        end else if (!last_stage) begin
                            stage_d = stage_q + 2'd1;
                            valid_d = 1'b0;
                            state_d = StLoad;
                        end else begin
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            key_q   <= '0;
            mode_q  <= 1'b0;
            stage_q <= 2'd0;
            round_q <= 4'd0;
            c_q     <= '0;
            d_q     <= '0;
            rk_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            stage_q <= stage_d;
            round_q <= round_d;
            c_q     <= c_d;
            d_q     <= d_d;
            rk_q    <= rk_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
        end
    end

    assign rk_valid   = valid_q;
    assign rk         = rk_q;
    assign rk_round   = round_q;
    assign rk_stage   = stage_q;
    assign rk_last    = valid_q && (round_q == 4'd15) && last_stage;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign parity_err = (PARITY_CHECK != 0) && perr_q;

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Bench for des_key_sched_seq: single-DES and TDEA instances checked against a textbook
// cumulative-shift subkey model, with random keys, random stalls, abort and async reset.
module tb_des_key_sched_seq;

    localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEYP = 64'h133457799BBCDFF0;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic         clk = 1'b0;
    logic         rst_n, sel, start, abort, mode, ready;
    logic [191:0] key_all;
    logic         v1, v3, l1, l3, b1, b3, d1, d3, p1, p3;
    logic [47:0]  rk1, rk3;
    logic [3:0]   rr1, rr3;
    logic [1:0]   rs1, rs3;
    logic         ov, ol, ob, od, op;
    logic [47:0]  ork;
    logic [3:0]   orr;
    logic [1:0]   ors;
    logic [47:0]  first_rk, last_rk;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    des_key_sched_seq #(.KEY_STAGES(1), .PARITY_CHECK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .abort(abort & ~sel),
        .des_mode(mode), .key_in(key_all[63:0]), .out_ready(ready & ~sel),
        .rk_valid(v1), .rk(rk1), .rk_round(rr1), .rk_stage(rs1), .rk_last(l1),
        .busy(b1), .done(d1), .parity_err(p1));

    des_key_sched_seq #(.KEY_STAGES(3), .PARITY_CHECK(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .abort(abort & sel),
        .des_mode(mode), .key_in(key_all), .out_ready(ready & sel),
        .rk_valid(v3), .rk(rk3), .rk_round(rr3), .rk_stage(rs3), .rk_last(l3),
        .busy(b3), .done(d3), .parity_err(p3));

    always_comb begin
        ov  = sel ? v3 : v1;
        ork = sel ? rk3 : rk1;
        orr = sel ? rr3 : rr1;
        ors = sel ? rs3 : rs1;
        ol  = sel ? l3 : l1;
        ob  = sel ? b3 : b1;
        od  = sel ? d3 : d1;
        op  = sel ? p3 : p1;
    end

    // Textbook subkey n (1..16): rotate PC-1 halves by the cumulative shift count.
    function automatic logic [47:0] des_subkey(input logic [63:0] k, input int n);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] o;
        int tot;
        for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        tot = 0;
        for (int j = 0; j < n; j++) tot += SH[j];
        repeat (tot) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2[i]];
        return o;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic interrupt(input int how);
        bit saw;
        if (how == 1) begin
            abort = 1'b1;
            ready = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            ready = 1'b0;
            check("abort_idle", {ov, ob, od}, 0);
        end else begin
            ready = 1'b0;
            #2 rst_n = 1'b0;
            #1 check("rst_async", {ov, ob, od, ork, orr}, 0);
            @(posedge clk); #1;
            rst_n = 1'b1;
        end
        saw = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (od || ob || ov) saw = 1'b1;
        end
        check("stay_idle", saw, 0);
    endtask

    // One schedule on the selected instance; intr 1/2 = abort/reset at the eighth key.
    task automatic run(input bit s3, input bit m, input logic [191:0] k, input bit stall,
                       input int intr, output logic [47:0] f_rk, output logic [47:0] l_rk);
        logic [47:0] exp_q[$];
        logic [53:0] held;
        logic [63:0] sk;
        int ns, total, got, cycles;
        bit fin, hold, early_done, bad0;
        ns    = s3 ? 3 : 1;
        total = 16 * ns;
        bad0  = 1'b0;
        f_rk  = '0;
        l_rk  = '0;
        for (int s = 0; s < ns; s++) begin
            int ki;
            bit dd;
            ki = (s3 && m) ? 2 - s : s;
            dd = s3 ? (m ^ (s == 1)) : m;
            sk = k[64*ki +: 64];
            if (s == 0)
                for (int b = 0; b < 8; b++) if ((^sk[8*b +: 8]) == 1'b0) bad0 = 1'b1;
            for (int r = 0; r < 16; r++) exp_q.push_back(des_subkey(sk, dd ? 16 - r : r + 1));
        end
        sel = s3; mode = m; key_all = k; ready = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = ~m; key_all = ~k;
        check("load_state", {ov, ob, op}, 3'b010);
        @(posedge clk); #1;
        check("first_valid", ov, 1);
        check("perr_load", op, bad0);
        got = 0; cycles = 0; hold = 1'b0; fin = 1'b0; early_done = 1'b0;
        while (!fin && cycles < 4000) begin
            if (hold) check("hold", {ov, ork, orr, ors}, {1'b1, held});
            if (od) early_done = 1'b1;
            if (ov && intr != 0 && got == 7) begin
                interrupt(intr);
                fin = 1'b1;
            end else begin
                ready = ov ? (stall ? ($urandom_range(0, 2) != 0) : 1'b1)
                           : ($urandom_range(0, 1) != 0);
                hold = ov && !ready;
                held = {ork, orr, ors};
                if (ov && ready) begin
                    check("rk", ork, exp_q[got]);
                    check("round_stage", {orr, ors}, {4'(got % 16), 2'(got / 16)});
                    check("last", ol, got == total - 1);
                    if (got == 0) f_rk = ork;
                    l_rk = ork;
                    got++;
                end
                @(posedge clk); #1;
                cycles++;
                if (got == total) begin
                    check("done_pulse", {od, ov}, 2'b10);
                    check("no_early_done", early_done, 0);
                    if (!stall) check("no_bubble", cycles, total + ns - 1);
                    @(posedge clk); #1;
                    check("done_drop", {od, ob}, 0);
                    fin = 1'b1;
                end
            end
        end
        ready = 1'b0;
        check("finished", fin, 1);
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; ready = 1'b0;
        key_all = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dut1", {v1, rk1, rr1, rs1, l1, b1, d1, p1}, 0);
        check("reset_dut3", {v3, rk3, rr3, rs3, l3, b3, d3, p3}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(0, 0, {128'd0, KEY}, 0, 0, first_rk, last_rk);
        check("enc_r0", first_rk, 48'h1B02EFFC7072);
        check("enc_r15", last_rk, 48'hCB3D8B0E17F5);
        check("good_parity", p1, 0);

        run(0, 1, {128'd0, KEY}, 0, 0, first_rk, last_rk);
        check("dec_r0", first_rk, 48'hCB3D8B0E17F5);
        check("dec_r15", last_rk, 48'h1B02EFFC7072);

        run(0, 0, {128'd0, KEY}, 1, 0, first_rk, last_rk);
        check("stall_r15", last_rk, 48'hCB3D8B0E17F5);
        run(0, 1, {128'd0, $urandom, $urandom}, 1, 0, first_rk, last_rk);

        run(0, 0, {128'd0, KEYP}, 0, 0, first_rk, last_rk);
        check("perr_sticky", p1, 1);
        check("perr_keys", first_rk, 48'h1B02EFFC7072);
        run(0, 0, {128'd0, KEY}, 0, 0, first_rk, last_rk);
        check("perr_cleared", p1, 0);

        run(0, 0, {128'd0, KEY}, 0, 1, first_rk, last_rk);
        run(0, 0, {128'd0, KEY}, 0, 0, first_rk, last_rk);
        check("abort_restart", first_rk, 48'h1B02EFFC7072);
        run(0, 1, {128'd0, KEY}, 1, 2, first_rk, last_rk);
        run(0, 0, {128'd0, KEY}, 0, 0, first_rk, last_rk);
        check("reset_restart", first_rk, 48'h1B02EFFC7072);

        run(1, 0, {KEY, KEY, KEY}, 0, 0, first_rk, last_rk);
        check("tdea_last", last_rk, 48'hCB3D8B0E17F5);
        run(1, 1, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1, 0,
            first_rk, last_rk);
        run(1, 0, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1, 0,
            first_rk, last_rk);
        run(1, 1, {KEY, KEY, KEY}, 0, 1, first_rk, last_rk);

        for (int i = 0; i < 3; i++)
            run(0, 1'($urandom_range(0, 1)), {128'd0, $urandom, $urandom}, 1, 0,
                first_rk, last_rk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
